// File: rtl/rs_issue_sched.sv
// Issue scheduler: per-FU round-robin pick of ready RS entries, held with a valid/ready handshake.
// Optional ISSUE_STATS_EN adds saturating per-FU issue and stall counters.
module rs_issue_sched #(
  parameter int RS_DEPTH = 16,
  parameter int IDX_W    = 4,
  parameter int NUM_FU   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [RS_DEPTH-1:0]       rs_valid,
  input  logic [RS_DEPTH-1:0]       rs_ready,
  input  logic [2*RS_DEPTH-1:0]     rs_fu,
  input  logic [NUM_FU-1:0]         fu_ready,
  output logic [NUM_FU-1:0]         issue_valid,
  output logic [IDX_W*NUM_FU-1:0]   issue_idx,
  output logic [RS_DEPTH-1:0]       rs_free
`ifdef ISSUE_STATS_EN
  ,
  output logic [32*NUM_FU-1:0]      stat_issued,
  output logic [32*NUM_FU-1:0]      stat_stall
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state     [NUM_FU];
  state_t              state_nxt [NUM_FU];
  logic [IDX_W-1:0]    idx_q     [NUM_FU];
  logic [IDX_W-1:0]    idx_nxt   [NUM_FU];
  logic [IDX_W-1:0]    rr_ptr    [NUM_FU];
  logic [IDX_W-1:0]    rr_nxt    [NUM_FU];
  logic [IDX_W-1:0]    sel       [NUM_FU];
  logic [NUM_FU-1:0]   found;
  logic [NUM_FU-1:0]   fire;
  logic [RS_DEPTH-1:0] inflight;
  logic [RS_DEPTH-1:0] inflight_nxt;

  // Round-robin scan: first eligible entry at or after rr_ptr, wrapping by truncation.
  always_comb begin
    logic [IDX_W-1:0] n;
    n = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      found[k] = 1'b0;
      sel[k]   = '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        n = rr_ptr[k] + IDX_W'(i);
        if (!found[k] && rs_valid[n] && rs_ready[n] && !inflight[n] &&
            (rs_fu[{n, 1'b0} +: 2] == 2'(k))) begin
          found[k] = 1'b1;
          sel[k]   = n;
        end
      end
    end
  end

  // Flush wins over accept, so a flushed hold neither fires nor frees.
  always_comb begin
    rs_free = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      fire[k] = (state[k] == HOLD) && fu_ready[k] && !flush;
      if (fire[k] && rs_valid[idx_q[k]]) rs_free[idx_q[k]] = 1'b1;
    end
  end

  always_comb begin
    inflight_nxt = inflight;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      state_nxt[k] = state[k];
      idx_nxt[k]   = idx_q[k];
      rr_nxt[k]    = rr_ptr[k];
      if (fire[k]) inflight_nxt[idx_q[k]] = 1'b0;
      if ((state[k] == IDLE || fire[k]) && found[k]) begin
        state_nxt[k]      = HOLD;
        idx_nxt[k]        = sel[k];
        rr_nxt[k]         = sel[k] + IDX_W'(1);
        inflight_nxt[sel[k]] = 1'b1;
      end else if (fire[k]) begin
        state_nxt[k] = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        state[k]  <= IDLE;
        idx_q[k]  <= '0;
        rr_ptr[k] <= '0;
      end
    end else if (flush) begin
      inflight <= '0;
      for (int unsigned k = 0; k < NUM_FU; k++) state[k] <= IDLE;
    end else begin
      inflight <= inflight_nxt;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        state[k]  <= state_nxt[k];
        idx_q[k]  <= idx_nxt[k];
        rr_ptr[k] <= rr_nxt[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      issue_valid[k]              = (state[k] == HOLD);
      issue_idx[IDX_W*k +: IDX_W] = idx_q[k];
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        if (fire[k] && stat_issued[32*k +: 32] != '1)
          stat_issued[32*k +: 32] <= stat_issued[32*k +: 32] + 32'd1;
        if (state[k] == HOLD && !fu_ready[k] && stat_stall[32*k +: 32] != '1)
          stat_stall[32*k +: 32] <= stat_stall[32*k +: 32] + 32'd1;
      end
    end
  end
`endif

  // The RS must not retire an entry while it is held by an FU.
  a_no_drop_inflight: assert property (@(posedge clk) disable iff (rst)
    ((inflight & ~rs_valid) == '0));

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched; models the RS clearing entries one edge after rs_free.
module tb_rs_issue_sched;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [15:0] rs_valid, rs_ready, rs_free;
  logic [31:0] rs_fu;
  logic [2:0]  fu_ready, issue_valid;
  logic [11:0] issue_idx;
`ifdef ISSUE_STATS_EN
  logic [95:0] stat_issued, stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_issue_sched #(.RS_DEPTH(16), .IDX_W(4), .NUM_FU(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_fu(rs_fu),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .rs_free(rs_free)
`ifdef ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the RS drops freed entries right after the edge.
  task automatic tick();
    logic [15:0] pf;
    pf = rs_free;
    @(posedge clk);
    #1;
    rs_valid = rs_valid & ~pf;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic add_entry(input int n, input logic [1:0] fu);
    rs_valid[n]        = 1'b1;
    rs_ready[n]        = 1'b1;
    rs_fu[2*n +: 2]    = fu;
  endtask

  initial begin
    // Reset with every input high
    rst = 1'b1; flush = 1'b1;
    rs_valid = '1; rs_ready = '1; rs_fu = '1; fu_ready = '1;
    tick(); tick();
    sample();
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_free",  32'(rs_free),     32'h0);
    chk("rst_idx",   32'(issue_idx),   32'h0);
    tick();
    rst = 1'b0; flush = 1'b0;
    rs_valid = '0; rs_ready = '0; rs_fu = '0; fu_ready = 3'b111;

    // Single issue on FU0
    add_entry(5, 2'd0);
    sample();
    chk("single_pre", 32'(issue_valid), 32'h0);
    tick(); sample();
    chk("single_valid", 32'(issue_valid),     32'h1);
    chk("single_idx",   32'(issue_idx[3:0]),  32'd5);
    chk("single_free",  32'(rs_free),         32'h0020);
    tick(); sample();
    chk("single_idle", 32'(issue_valid), 32'h0);
    chk("single_nofree", 32'(rs_free), 32'h0);

    // Round robin on FU1: 2, 7, 12 back to back
    add_entry(2, 2'd1); add_entry(7, 2'd1); add_entry(12, 2'd1);
    tick(); sample();
    chk("rr_idx_a",  32'(issue_idx[7:4]), 32'd2);
    chk("rr_free_a", 32'(rs_free),        32'h0004);
    tick(); sample();
    chk("rr_idx_b",  32'(issue_idx[7:4]), 32'd7);
    chk("rr_free_b", 32'(rs_free),        32'h0080);
    tick(); sample();
    chk("rr_idx_c",  32'(issue_idx[7:4]), 32'd12);
    chk("rr_free_c", 32'(rs_free),        32'h1000);
    tick(); sample();
    chk("rr_idle", 32'(issue_valid), 32'h0);
    // Pointer sits at 13: entry 14 must beat the re-raised entry 2
    add_entry(2, 2'd1); add_entry(14, 2'd1);
    tick(); sample();
    chk("rr_wrap_a", 32'(issue_idx[7:4]), 32'd14);
    tick(); sample();
    chk("rr_wrap_b", 32'(issue_idx[7:4]), 32'd2);
    tick(); sample();
    chk("rr_wrap_idle", 32'(issue_valid), 32'h0);

    // Backpressure on FU2
    fu_ready = 3'b011;
    add_entry(9, 2'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("bp_valid", 32'(issue_valid[2]),   32'h1);
      chk("bp_idx",   32'(issue_idx[11:8]),  32'd9);
      chk("bp_free",  32'(rs_free),          32'h0);
      tick();
    end
    fu_ready = 3'b111;
    sample();
    chk("bp_accept_free", 32'(rs_free), 32'h0200);
    tick(); sample();
    chk("bp_idle", 32'(issue_valid), 32'h0);
`ifdef ISSUE_STATS_EN
    chk("bp_stat_stall", stat_stall[95:64], 32'd4);
`endif

    // Parallel issue on all three FUs
    add_entry(0, 2'd0); add_entry(1, 2'd1); add_entry(3, 2'd2);
    tick(); sample();
    chk("par_valid", 32'(issue_valid), 32'h7);
    chk("par_free",  32'(rs_free),     32'h000B);
    tick(); sample();
    chk("par_idle", 32'(issue_valid), 32'h0);

    // Flush while FU0 holds entry 4
    fu_ready = 3'b110;
    add_entry(4, 2'd0);
    tick();
    flush = 1'b1; fu_ready = 3'b111;
    sample();
    chk("fl_held",   32'(issue_valid[0]), 32'h1);
    chk("fl_nofree", 32'(rs_free),        32'h0);
    tick();
    flush = 1'b0;
    sample();
    chk("fl_idle", 32'(issue_valid[0]), 32'h0);
    tick(); sample();
    chk("fl_reissue_v",   32'(issue_valid[0]), 32'h1);
    chk("fl_reissue_idx", 32'(issue_idx[3:0]), 32'd4);
    chk("fl_reissue_free", 32'(rs_free),       32'h0010);
    tick(); sample();
    chk("fl_done", 32'(issue_valid), 32'h0);

    // All 16 entries on FU2; pointer is at 4 after entry 3
    for (int n = 0; n < 16; n++) add_entry(n, 2'd2);
    tick();
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("all_idx",  32'(issue_idx[11:8]), 32'((4 + i) % 16));
      chk("all_free", 32'(rs_free),         32'(1) << ((4 + i) % 16));
      tick();
    end
    sample();
    chk("all_idle",  32'(issue_valid), 32'h0);
    chk("all_empty", 32'(rs_valid),    32'h0);
`ifdef ISSUE_STATS_EN
    chk("stat_issued0", stat_issued[31:0],  32'd3);
    chk("stat_issued1", stat_issued[63:32], 32'd6);
    chk("stat_issued2", stat_issued[95:64], 32'd18);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
